// File: rtl/bcd_to_binary.sv
// Sequential BCD-to-binary converter using reverse double-dabble, one bit per clock.
// Build option BCD2BIN_ERR_STICKY_EN: err stays set until reset once any conversion is invalid.
module bcd_to_binary #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [BIN_W-1:0]      binary
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    // Handshake: start is sampled on a rising edge only in IDLE or DONE; busy is high
    // exactly while converting; done is a one-cycle pulse during which binary/err are valid.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [BCD_W-1:0]     bcd_sr_q, bcd_sr_d;
    logic [BIN_W-1:0]     bin_sr_q, bin_sr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 err_pending_q, err_pending_d;
    logic                 err_q, err_d;
    logic [BIN_W-1:0]     binary_q, binary_d;

    logic [BCD_W+BIN_W-1:0] shifted;
    logic [BCD_W-1:0]       bcd_adj;
    logic                   bcd_invalid;

    // One iteration: shift right, then correct every digit that landed at 8 or above.
    always_comb begin
        shifted = {bcd_sr_q, bin_sr_q} >> 1;
        bcd_adj = shifted[BCD_W+BIN_W-1:BIN_W];
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_adj[4*i+3]) begin
                bcd_adj[4*i +: 4] = bcd_adj[4*i +: 4] - 4'd3;
            end
        end
    end

    always_comb begin
        bcd_invalid = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_in[4*i +: 4] > 4'd9) begin
                bcd_invalid = 1'b1;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        bcd_sr_d      = bcd_sr_q;
        bin_sr_d      = bin_sr_q;
        cnt_d         = cnt_q;
        err_pending_d = err_pending_q;
        err_d         = err_q;
        binary_d      = binary_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d       = CONVERT;
                    bcd_sr_d      = bcd_in;
                    bin_sr_d      = '0;
                    cnt_d         = CNT_W'(BIN_W);
                    err_pending_d = bcd_invalid;
`ifndef BCD2BIN_ERR_STICKY_EN
                    err_d         = 1'b0;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            CONVERT: begin
                bcd_sr_d = bcd_adj;
                bin_sr_d = shifted[BIN_W-1:0];
                cnt_d    = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d  = DONE;
                    binary_d = err_pending_q ? '0 : shifted[BIN_W-1:0];
`ifdef BCD2BIN_ERR_STICKY_EN
                    err_d    = err_q | err_pending_q;
`else
                    err_d    = err_pending_q;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            bcd_sr_q      <= '0;
            bin_sr_q      <= '0;
            cnt_q         <= '0;
            err_pending_q <= 1'b0;
            err_q         <= 1'b0;
            binary_q      <= '0;
        end else begin
            state_q       <= state_d;
            bcd_sr_q      <= bcd_sr_d;
            bin_sr_q      <= bin_sr_d;
            cnt_q         <= cnt_d;
            err_pending_q <= err_pending_d;
            err_q         <= err_d;
            binary_q      <= binary_d;
        end
    end

    assign busy   = (state_q == CONVERT);
    assign done   = (state_q == DONE);
    assign err    = err_q;
    assign binary = binary_q;

endmodule
